// File: rtl/mem_arbiter_if.sv
// Bus bundle for the two-requester memory arbiter: both request ports, the shared
// memory port and the status outputs. The arbiter uses master, the environment slave.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              grant;

    modport master (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output ack0, rdata0, ack1, rdata1,
        output mem_addr, mem_wdata, mem_we, mem_re,
        output busy, grant
    );

    modport slave (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        input  busy, grant
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-cycle memory between two requesters.
// Each transaction runs IDLE -> ACCESS -> DONE, giving a fixed 3-cycle cadence.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.master bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic any_req;
    logic pick;
    logic in_access;
    logic in_done;

    assign any_req = bus.req0 | bus.req1;
    // grant_q doubles as last_grant: on a tie the port that was not served last wins.
    assign pick    = (bus.req0 && bus.req1) ? ~grant_q : bus.req1;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = IDLE;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ACCESS;
                    grant_d = pick;
                    we_d    = pick ? bus.we1    : bus.we0;
                    addr_d  = pick ? bus.addr1  : bus.addr0;
                    wdata_d = pick ? bus.wdata1 : bus.wdata0;
                end
            end
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // NOTE: the request latches carry no reset; they are only consumed after a grant reloads them.
    always_ff @(posedge clock) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign in_access = (state_q == ACCESS);
    assign in_done   = (state_q == DONE);

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = in_access & we_q;
    assign bus.mem_re    = in_access & ~we_q;

    // Memory read data arrives the cycle after mem_re, which is exactly the DONE cycle.
    assign bus.ack0   = in_done & ~grant_q;
    assign bus.ack1   = in_done & grant_q;
    assign bus.rdata0 = bus.mem_rdata;
    assign bus.rdata1 = bus.mem_rdata;

    assign bus.busy  = (state_q != IDLE);
    assign bus.grant = grant_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios, then randomized traffic, all checked
// against a transaction-level model that predicts outputs from grant timestamps.
module tb_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // Environment memory: answers mem_re one cycle later, commits mem_we on the edge.
    logic [DATA_W-1:0] env_mem [logic [ADDR_W-1:0]];
    always @(posedge clock) begin
        if (bus.mem_we)
            env_mem[bus.mem_addr] = bus.mem_wdata;
        if (bus.mem_re)
            bus.mem_rdata <= env_mem.exists(bus.mem_addr) ? env_mem[bus.mem_addr] : init_val(bus.mem_addr);
    end

    // Reference model: one record of the current transaction plus the edge it was granted on.
    logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
    int                cyc     = 0;
    int                t_grant = -10;
    bit                m_last  = 1'b1;
    bit                m_port;
    bit                m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    int                ack_port [$];
    int                ack_cyc  [$];

    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic model_edge();
        cyc++;
        if (reset) begin
            t_grant = -10;
            m_last  = 1'b1;
        end else if ((cyc - 1 >= t_grant + 2) && (bus.req0 || bus.req1)) begin
            m_port  = (bus.req0 && bus.req1) ? !m_last : !bus.req0;
            m_we    = m_port ? bus.we1    : bus.we0;
            m_addr  = m_port ? bus.addr1  : bus.addr0;
            m_wdata = m_port ? bus.wdata1 : bus.wdata0;
            m_last  = m_port;
            t_grant = cyc;
            if (m_we) ref_mem[m_addr] = m_wdata;
            else      m_rdata = ref_read(m_addr);
        end
    endtask

    task automatic check_cycle();
        bit acc = (cyc == t_grant);
        bit dn  = (cyc == t_grant + 1);
        check("ack0",   bus.ack0,   dn && !m_port);
        check("ack1",   bus.ack1,   dn && m_port);
        check("mem_we", bus.mem_we, acc && m_we);
        check("mem_re", bus.mem_re, acc && !m_we);
        check("busy",   bus.busy,   acc || dn);
        check("grant",  bus.grant,  m_last);
        if (acc) begin
            check("mem_addr", bus.mem_addr, m_addr);
            if (m_we) check("mem_wdata", bus.mem_wdata, m_wdata);
        end
        if (dn && !m_we)
            check("rdata", m_port ? bus.rdata1 : bus.rdata0, m_rdata);
        check("ack_excl",    bus.ack0 & bus.ack1, 1'b0);
        check("strobe_excl", bus.mem_we & bus.mem_re, 1'b0);
        check("strobe_only_access", (bus.mem_we | bus.mem_re) & (~bus.busy | bus.ack0 | bus.ack1), 1'b0);
        if (bus.ack0) begin ack_port.push_back(0); ack_cyc.push_back(cyc); end
        if (bus.ack1) begin ack_port.push_back(1); ack_cyc.push_back(cyc); end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_cycle();
        @(negedge clock);
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        return ADDR_W'($urandom_range(15)) << 2;
    endfunction

    initial begin
        int exp_order [4] = '{0, 1, 0, 1};
        bit a0, a1;

        reset = 1'b1;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        env_mem[32'h10] = 32'hDEAD_BEEF;
        ref_mem[32'h10] = 32'hDEAD_BEEF;

        step();
        check("rst_grant", bus.grant, 1'b1);
        check("rst_busy",  bus.busy,  1'b0);
        step();
        reset = 1'b0;
        step();

        // Single read on port 0.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h10;
        step();
        check("rd_re",   bus.mem_re,   1'b1);
        check("rd_addr", bus.mem_addr, 32'h10);
        step();
        check("rd_ack0",  bus.ack0,   1'b1);
        check("rd_data0", bus.rdata0, 32'hDEAD_BEEF);
        bus.req0 = 1'b0;
        step();

        // Single write on port 1, then read it back on port 0.
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h20; bus.wdata1 = 32'h1234_5678;
        step();
        check("wr_we",    bus.mem_we,    1'b1);
        check("wr_addr",  bus.mem_addr,  32'h20);
        check("wr_wdata", bus.mem_wdata, 32'h1234_5678);
        step();
        check("wr_ack1",  bus.ack1,   1'b1);
        check("wr_we_1c", bus.mem_we, 1'b0);
        bus.req1 = 1'b0;
        step();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h20;
        step();
        step();
        check("wr_readback", bus.rdata0, 32'h1234_5678);
        bus.req0 = 1'b0;
        step();

        // Tie after reset: both requests held for four transactions.
        reset = 1'b1;
        step();
        reset = 1'b0;
        ack_port.delete();
        ack_cyc.delete();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h10;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h20;
        for (int i = 0; i < 12; i++) step();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        check("tie_count", ack_port.size(), 4);
        for (int i = 0; i < ack_port.size() && i < 4; i++)
            check("tie_order", ack_port[i], exp_order[i]);
        for (int i = 1; i < ack_cyc.size(); i++)
            check("tie_gap", ack_cyc[i] - ack_cyc[i-1], 3);
        step();

        // Inputs change and request drops while the transaction is in flight.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h10;
        step();
        bus.addr0 = 32'h30;
        bus.req0  = 1'b0;
        #1;
        check("mid_addr", bus.mem_addr, 32'h10);
        step();
        check("mid_ack0", bus.ack0, 1'b1);
        step();

        // Reset during ACCESS aborts without an ack; the next request completes.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h40;
        step();
        reset = 1'b1;
        step();
        check("rst_mid_busy", bus.busy, 1'b0);
        check("rst_mid_ack",  bus.ack0, 1'b0);
        reset = 1'b0;
        step();
        step();
        check("post_rst_ack0", bus.ack0, 1'b1);
        bus.req0 = 1'b0;
        step();

        // Randomized traffic with occasional resets and in-flight input noise.
        for (int k = 0; k < 2000; k++) begin
            a0 = bus.ack0;
            a1 = bus.ack1;
            if (a0) bus.req0 = 1'b0;
            else if (!bus.req0) begin
                if ($urandom_range(3) == 0) begin
                    bus.req0 = 1'b1; bus.we0 = 1'($urandom);
                    bus.addr0 = rand_addr(); bus.wdata0 = $urandom;
                end
            end else if ($urandom_range(7) == 0) begin
                bus.addr0 = rand_addr(); bus.wdata0 = $urandom; bus.we0 = 1'($urandom);
            end
            if (a1) bus.req1 = 1'b0;
            else if (!bus.req1) begin
                if ($urandom_range(3) == 0) begin
                    bus.req1 = 1'b1; bus.we1 = 1'($urandom);
                    bus.addr1 = rand_addr(); bus.wdata1 = $urandom;
                end
            end else if ($urandom_range(7) == 0) begin
                bus.addr1 = rand_addr(); bus.wdata1 = $urandom; bus.we1 = 1'($urandom);
            end
            reset = ($urandom_range(150) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
